// File: rtl/cheat_pgm_sched.sv
// cheat_pgm_sched: queues MCU cheat/hook configuration writes and replays them
// into the cheat engine programming port only inside a safe window after each
// SNES bus cycle start. Slot writes to enabled slots are wrapped in
// mask-off / write / mask-restore so the engine never fetches a half-updated slot.
// Optional feature macro: CHEAT_SCHED_TIMEOUT_EN (opens the window permanently
// once the SNES has produced no cycle start for TIMEOUT clocks).
module cheat_pgm_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_START  = 8,
  parameter int WIN_END    = 40,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mcu_wr_valid,
  output logic        mcu_wr_ready,
  input  logic [2:0]  mcu_idx,
  input  logic [31:0] mcu_data,
  input  logic        snes_cycle_start,
  output logic [2:0]  pgm_idx,
  output logic [31:0] pgm_in,
  output logic        pgm_we,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0]  WS8   = 8'(WIN_START);
  localparam logic [7:0]  WE8   = 8'(WIN_END);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
  localparam logic [2:0]  IDX_MASK  = 3'd6;
  localparam logic [2:0]  IDX_FLAGS = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DISPATCH  = 3'd1,
    ST_ISSUE_RAW = 3'd2,
    ST_MASK_OFF  = 3'd3,
    ST_SLOT      = 3'd4,
    ST_MASK_ON   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cyc_cnt_q, cyc_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    cmd_idx_q, cmd_idx_d;
  logic [31:0]   cmd_data_q, cmd_data_d;
  logic [5:0]    shadow_q, shadow_d;
  logic          pgm_we_q, pgm_we_d;
  logic [2:0]    pgm_idx_q, pgm_idx_d;
  logic [31:0]   pgm_in_q, pgm_in_d;
  logic          overflow_q, overflow_d;

  logic [2:0]    fifo_idx_q  [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];

  logic          full_s, empty_s, push_s, pop_s, win_ok_s;
  logic [5:0]    slot_mask_s;

`ifdef CHEAT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  assign full_s       = (count_q == DEPTH);
  assign empty_s      = (count_q == '0);
  assign push_s       = mcu_wr_valid & ~full_s;
  assign pop_s        = (state_q == ST_IDLE) & ~empty_s;
  assign slot_mask_s  = 6'd1 << cmd_idx_q;
  assign mcu_wr_ready = ~full_s;
  assign busy         = ~empty_s | (state_q != ST_IDLE);
  assign pgm_we       = pgm_we_q;
  assign pgm_idx      = pgm_idx_q;
  assign pgm_in       = pgm_in_q;
  assign overflow     = overflow_q;

  // Window qualification from the registered cycle counter (plus SNES-dead override).
  always_comb begin
    win_ok_s = (cyc_cnt_q >= WS8) && (cyc_cnt_q <= WE8);
`ifdef CHEAT_SCHED_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
    if (snes_cycle_start) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TO_VAL) begin
      idle_cnt_d = idle_cnt_q + TW'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
    if (idle_cnt_q == TO_VAL) begin
      win_ok_s = 1'b1;
    end else begin
      win_ok_s = win_ok_s;
    end
`endif
  end

  // Next-state for cycle counter, FIFO bookkeeping, sequencer FSM and outputs.
  always_comb begin
    state_d    = state_q;
    cmd_idx_d  = cmd_idx_q;
    cmd_data_d = cmd_data_q;
    shadow_d   = shadow_q;
    pgm_we_d   = 1'b0;
    pgm_idx_d  = pgm_idx_q;
    pgm_in_d   = pgm_in_q;
    overflow_d = overflow_q | (mcu_wr_valid & full_s);

    if (snes_cycle_start) begin
      cyc_cnt_d = 8'd0;
    end else if (cyc_cnt_q != 8'hff) begin
      cyc_cnt_d = cyc_cnt_q + 8'd1;
    end else begin
      cyc_cnt_d = cyc_cnt_q;
    end

    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          cmd_idx_d  = fifo_idx_q[rd_ptr_q];
          cmd_data_d = fifo_data_q[rd_ptr_q];
          state_d    = ST_DISPATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        if (cmd_idx_q == IDX_MASK) begin
          shadow_d = cmd_data_q[5:0];
          state_d  = ST_ISSUE_RAW;
        end else if (cmd_idx_q == IDX_FLAGS) begin
          state_d = ST_ISSUE_RAW;
        end else if ((shadow_q & slot_mask_s) != 6'd0) begin
          state_d = ST_MASK_OFF;
        end else begin
          state_d = ST_ISSUE_RAW;
        end
      end
      ST_ISSUE_RAW: begin
        if (win_ok_s) begin
          pgm_we_d  = 1'b1;
          pgm_idx_d = cmd_idx_q;
          pgm_in_d  = cmd_data_q;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_ISSUE_RAW;
        end
      end
      ST_MASK_OFF: begin
        if (win_ok_s) begin
          pgm_we_d  = 1'b1;
          pgm_idx_d = IDX_MASK;
          pgm_in_d  = {26'd0, shadow_q & ~slot_mask_s};
          state_d   = ST_SLOT;
        end else begin
          state_d = ST_MASK_OFF;
        end
      end
      ST_SLOT: begin
        if (win_ok_s) begin
          pgm_we_d  = 1'b1;
          pgm_idx_d = cmd_idx_q;
          pgm_in_d  = cmd_data_q;
          state_d   = ST_MASK_ON;
        end else begin
          state_d = ST_SLOT;
        end
      end
      ST_MASK_ON: begin
        if (win_ok_s) begin
          pgm_we_d  = 1'b1;
          pgm_idx_d = IDX_MASK;
          pgm_in_d  = {26'd0, shadow_q};
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_MASK_ON;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_idx_q[wr_ptr_q]  <= mcu_idx;
      fifo_data_q[wr_ptr_q] <= mcu_data;
    end
  end

  // All control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cyc_cnt_q  <= 8'hff;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_idx_q  <= 3'd0;
      cmd_data_q <= 32'd0;
      shadow_q   <= 6'h00;
      pgm_we_q   <= 1'b0;
      pgm_idx_q  <= 3'd0;
      pgm_in_q   <= 32'd0;
      overflow_q <= 1'b0;
`ifdef CHEAT_SCHED_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cmd_idx_q  <= cmd_idx_d;
      cmd_data_q <= cmd_data_d;
      shadow_q   <= shadow_d;
      pgm_we_q   <= pgm_we_d;
      pgm_idx_q  <= pgm_idx_d;
      pgm_in_q   <= pgm_in_d;
      overflow_q <= overflow_d;
`ifdef CHEAT_SCHED_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_cheat_pgm_sched.sv
// Self-checking bench for cheat_pgm_sched: directed scenarios plus random
// traffic, checked against a write-sequence model that expands each accepted
// MCU command into the programming-port writes it must produce.
module tb_cheat_pgm_sched;

  localparam int FD = 4;
  localparam int WS = 8;
  localparam int WE = 40;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mcu_wr_valid = 1'b0;
  logic        mcu_wr_ready;
  logic [2:0]  mcu_idx = 3'd0;
  logic [31:0] mcu_data = 32'd0;
  logic        snes_cycle_start = 1'b0;
  logic [2:0]  pgm_idx;
  logic [31:0] pgm_in;
  logic        pgm_we;
  logic        busy;
  logic        overflow;

  cheat_pgm_sched #(.FIFO_DEPTH(FD), .WIN_START(WS), .WIN_END(WE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mcu_wr_valid(mcu_wr_valid), .mcu_wr_ready(mcu_wr_ready),
    .mcu_idx(mcu_idx), .mcu_data(mcu_data),
    .snes_cycle_start(snes_cycle_start),
    .pgm_idx(pgm_idx), .pgm_in(pgm_in), .pgm_we(pgm_we),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_we = 0;
  int          last_we_cnt = -1;
  int          m_cnt = 255;
  int          m_idle = 0;
  logic [5:0]  m_shadow = 6'd0;
  bit          m_ovf = 1'b0;
  int          exp_idx[$];
  logic [31:0] exp_data[$];
  int          period = 0;
  int          phase = 0;
  bit          force_start = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_exp(input int idx, input logic [31:0] d);
    exp_idx.push_back(idx);
    exp_data.push_back(d);
  endtask

  // Expand one accepted command into the writes the engine must see.
  task automatic model_push(input int idx, input logic [31:0] d);
    logic [5:0] bitm;
    if (idx == 6) begin
      m_shadow = d[5:0];
      add_exp(6, d);
    end else if (idx == 7) begin
      add_exp(7, d);
    end else begin
      bitm = 6'd1 << idx;
      if ((m_shadow & bitm) != 6'd0) begin
        add_exp(6, {26'd0, m_shadow & ~bitm});
        add_exp(idx, d);
        add_exp(6, {26'd0, m_shadow});
      end else begin
        add_exp(idx, d);
      end
    end
  endtask

  // One clock: drive strobe, advance the model, check outputs after the edge.
  task automatic tick();
    bit          start, acc, win;
    int          at_cnt, s_idx;
    logic [31:0] s_data;
    start = force_start || (period != 0 && phase == period - 1);
    snes_cycle_start = start;
    acc    = rst_n && mcu_wr_valid && mcu_wr_ready;
    s_idx  = int'(mcu_idx);
    s_data = mcu_data;
    if (rst_n && mcu_wr_valid && !mcu_wr_ready) m_ovf = 1'b1;
    win = (m_cnt >= WS && m_cnt <= WE);
`ifdef CHEAT_SCHED_TIMEOUT_EN
    if (m_idle >= TO) win = 1'b1;
`endif
    at_cnt = m_cnt;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (acc) model_push(s_idx, s_data);
      m_cnt  = start ? 0 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      m_idle = start ? 0 : ((m_idle < TO) ? m_idle + 1 : TO);
    end
    phase = (period != 0) ? (phase + 1) % period : 0;
    snes_cycle_start = 1'b0;
    force_start = 1'b0;
    mcu_wr_valid = 1'b0;
    if (pgm_we) begin
      n_we++;
      last_we_cnt = at_cnt;
      if (exp_idx.size() == 0) begin
        check_eq("we_unexpected", 32'd1, 32'd0);
      end else begin
        check_eq("we_idx", {29'd0, pgm_idx}, exp_idx.pop_front());
        check_eq("we_data", pgm_in, exp_data.pop_front());
        check_eq("we_window", {31'd0, win}, 32'd1);
      end
    end
    check_eq("busy", {31'd0, busy}, {31'd0, exp_idx.size() != 0});
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic push(input int idx, input logic [31:0] d);
    mcu_wr_valid = 1'b1;
    mcu_idx = idx[2:0];
    mcu_data = d;
    tick();
  endtask

  task automatic wait_we(input int target, input int maxc);
    int k = 0;
    while (n_we < target && k < maxc) begin
      tick();
      k++;
    end
    if (n_we < target) check_eq("we_timeout", n_we, target);
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((exp_idx.size() != 0 || busy) && k < maxc) begin
      tick();
      k++;
    end
    check_eq("drain_left", exp_idx.size(), 32'd0);
  endtask

  // Asynchronous reset: outputs must be at reset values without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    mcu_wr_valid = 1'b0;
    period = 0;
    phase = 0;
    exp_idx.delete();
    exp_data.delete();
    m_cnt = 255;
    m_idle = 0;
    m_shadow = 6'd0;
    m_ovf = 1'b0;
    #1;
    check_eq("rst_we", {31'd0, pgm_we}, 32'd0);
    check_eq("rst_idx", {29'd0, pgm_idx}, 32'd0);
    check_eq("rst_in", pgm_in, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst_ready", {31'd0, mcu_wr_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    do_reset();

    // Single flags write lands inside a window; busy clear afterwards.
    period = 96;
    n0 = n_we;
    push(7, 32'h0000_0003);
    wait_we(n0 + 1, 300);
    tick();
    check_eq("t1_count", n_we - n0, 32'd1);

    // Mask set then enabled-slot update: atomic four-write sequence.
    n0 = n_we;
    push(6, 32'h0000_0005);
    push(2, 32'h00FF_EA12);
    drain(400);
    check_eq("t2_count", n_we - n0, 32'd4);

    // Slot update with mask clear: one raw write only.
    do_reset();
    period = 96;
    n0 = n_we;
    push(1, 32'h1234_5678);
    drain(400);
    check_eq("t3_count", n_we - n0, 32'd1);

    // No SNES clock: one command is held in the sequencer, FD more fill the FIFO.
    do_reset();
    n0 = n_we;
    for (int i = 0; i <= FD; i++) begin
      push(7, i);
      check_eq("fill_ready", {31'd0, mcu_wr_ready}, (i < FD) ? 32'd1 : 32'd0);
    end
    push(7, 32'h99);
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
`ifdef CHEAT_SCHED_TIMEOUT_EN
    drain(1500);
`else
    repeat (200) tick();
    check_eq("no_snes_hold", n_we - n0, 32'd0);
    period = 96;
    drain(2000);
`endif
    check_eq("fill_drained", n_we - n0, FD + 1);

    // Reset while the mask-restore write is pending.
    do_reset();
    period = 96;
    n0 = n_we;
    push(6, 32'h0000_0003);
    push(1, 32'hCAFE_0001);
    wait_we(n0 + 3, 400);
    do_reset();
    period = 96;
    n0 = n_we;
    repeat (300) tick();
    check_eq("post_rst_quiet", n_we - n0, 32'd0);

    // Cycle start at counter 20 restarts the window wait.
    do_reset();
    force_start = 1'b1;
    tick();
    while (m_cnt != 20) tick();
    n0 = n_we;
    force_start = 1'b1;
    push(7, 32'h0000_00A5);
    wait_we(n0 + 1, 100);
    check_eq("restart_cnt", last_we_cnt, 32'd8);

    // Random traffic with random cycle period and stray cycle starts.
    do_reset();
    period = $urandom_range(60, 120);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && mcu_wr_ready) begin
        mcu_wr_valid = 1'b1;
        mcu_idx = 3'($urandom_range(0, 7));
        mcu_data = $urandom;
      end
      if ($urandom_range(0, 199) == 0) force_start = 1'b1;
      tick();
    end
    drain(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
